// File: rtl/wash_sequencer.sv
// Washing-machine cycle controller: steps FILL/WASH/RINSE/SPIN on a one-second
// prescaler, enforces the lid interlock and counts lid violations for billing.
module wash_sequencer #(
  parameter int         TICK_DIV = 100000000,
  parameter logic [7:0] FILL_S   = 8'd10,
  parameter logic [7:0] WASH_S0  = 8'd20,
  parameter logic [7:0] WASH_S1  = 8'd40,
  parameter logic [7:0] WASH_S2  = 8'd60,
  parameter logic [7:0] WASH_S3  = 8'd0,
  parameter logic [7:0] RINSE_S  = 8'd20,
  parameter logic [7:0] SPIN_S   = 8'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] mode,
  input  logic       lid_open,
  output logic [2:0] phase,
  output logic [7:0] remaining,
  output logic       busy,
  output logic       lid_lock,
  output logic       fine_pulse,
  output logic [3:0] viol_cnt,
  output logic       done,
  output logic [1:0] cur_mode
);

  localparam int             PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TICK_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FILL = 3'd1, S_WASH = 3'd2, S_RINSE = 3'd3,
    S_SPIN = 3'd4, S_PAUSE = 3'd5, S_DONE = 3'd6
  } state_t;

  state_t        state, state_n, saved, saved_n;
  logic [PW-1:0] pre, pre_n;
  logic [7:0]    rem_n, wash_dur;
  logic [3:0]    viol_n;
  logic [1:0]    mode_n;
  logic          fine_n, done_n, busy_n, lock_n, tick;

  always_comb begin
    case (cur_mode)
      2'd0:    wash_dur = WASH_S0;
      2'd1:    wash_dur = WASH_S1;
      2'd2:    wash_dur = WASH_S2;
      default: wash_dur = WASH_S3;
    endcase
  end

  assign tick = (pre == TICK_MAX);

  always_comb begin
    state_n = state;
    saved_n = saved;
    rem_n   = remaining;
    pre_n   = pre;
    viol_n  = viol_cnt;
    mode_n  = cur_mode;
    fine_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !lid_open) begin
          mode_n  = mode;
          viol_n  = 4'd0;
          pre_n   = '0;
          rem_n   = FILL_S;
          state_n = S_FILL;
        end
      end
      S_FILL, S_WASH, S_RINSE, S_SPIN: begin
        if (abort) begin
          state_n = S_IDLE;
          rem_n   = 8'd0;
          pre_n   = '0;
        end else if (lid_open) begin
          // remaining and prescaler stay frozen until resume
          state_n = S_PAUSE;
          saved_n = state;
          fine_n  = 1'b1;
          if (viol_cnt != 4'd15) viol_n = viol_cnt + 4'd1;
        end else if (remaining == 8'd0 || (tick && remaining == 8'd1)) begin
          pre_n = '0;
          case (state)
            S_FILL:  begin state_n = S_WASH;  rem_n = wash_dur; end
            S_WASH:  begin state_n = S_RINSE; rem_n = RINSE_S;  end
            S_RINSE: begin state_n = S_SPIN;  rem_n = SPIN_S;   end
            default: begin state_n = S_DONE;  rem_n = 8'd0; done_n = 1'b1; end
          endcase
        end else if (tick) begin
          rem_n = remaining - 8'd1;
          pre_n = '0;
        end else begin
          pre_n = pre + 1'b1;
        end
      end
      S_PAUSE: begin
        if (abort) begin
          state_n = S_IDLE;
          rem_n   = 8'd0;
          pre_n   = '0;
        end else if (start && !lid_open) begin
          state_n = saved;
        end
      end
      default: begin
        state_n = S_IDLE;
        rem_n   = 8'd0;
      end
    endcase
    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    lock_n = busy_n && (state_n != S_PAUSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      saved      <= S_FILL;
      remaining  <= 8'd0;
      pre        <= '0;
      viol_cnt   <= 4'd0;
      cur_mode   <= 2'd0;
      fine_pulse <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      lid_lock   <= 1'b0;
    end else begin
      state      <= state_n;
      saved      <= saved_n;
      remaining  <= rem_n;
      pre        <= pre_n;
      viol_cnt   <= viol_n;
      cur_mode   <= mode_n;
      fine_pulse <= fine_n;
      done       <= done_n;
      busy       <= busy_n;
      lid_lock   <= lock_n;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with a 4-cycle tick and short phase times.
module tb_wash_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, abort = 1'b0, lid_open = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] phase;
  logic [7:0] remaining;
  logic       busy, lid_lock, fine_pulse, done;
  logic [3:0] viol_cnt;
  logic [1:0] cur_mode;

  int n_chk = 0, n_fail = 0;
  int lock_cnt = 0, fine_cnt = 0;

  wash_sequencer #(
    .TICK_DIV(4), .FILL_S(8'd2), .WASH_S0(8'd3), .WASH_S3(8'd0),
    .RINSE_S(8'd2), .SPIN_S(8'd1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .lid_open(lid_open), .phase(phase), .remaining(remaining), .busy(busy),
    .lid_lock(lid_lock), .fine_pulse(fine_pulse), .viol_cnt(viol_cnt),
    .done(done), .cur_mode(cur_mode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // each second of a phase spans 4 cycles
  task automatic run_phase(input int ph, input int secs);
    for (int s = secs; s >= 1; s--)
      for (int c = 0; c < 4; c++) begin
        chk("run_phase", phase, ph);
        chk("run_remaining", remaining, s);
        lock_cnt += lid_lock;
        fine_cnt += fine_pulse;
        step();
      end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_remaining"}, remaining, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_lid_lock"}, lid_lock, 0);
    chk({tag, "_fine"}, fine_pulse, 0);
    chk({tag, "_viol"}, viol_cnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cur_mode"}, cur_mode, 0);
  endtask

  initial begin
    #12;
    chk_reset_vals("reset");
    rst = 1'b1;
    step();
    chk("idle_hold", phase, 0);

    // normal mode 0
    mode = 2'd0; start = 1'b1; step(); start = 1'b0;
    chk("m0_busy", busy, 1);
    run_phase(1, 2);
    run_phase(2, 3);
    run_phase(3, 2);
    run_phase(4, 1);
    chk("m0_done_phase", phase, 6);
    chk("m0_done", done, 1);
    chk("m0_done_rem", remaining, 0);
    chk("m0_done_lock", lid_lock, 0);
    step();
    chk("m0_idle", phase, 0);
    chk("m0_done_clr", done, 0);
    chk("m0_lock_cycles", lock_cnt, 32);
    chk("m0_fines", fine_cnt, 0);

    // mode 3: zero-length wash
    mode = 2'd3; start = 1'b1; step(); start = 1'b0; mode = 2'd0;
    chk("m3_cur_mode", cur_mode, 3);
    run_phase(1, 2);
    chk("m3_wash", phase, 2);
    chk("m3_wash_rem", remaining, 0);
    step();
    run_phase(3, 2);
    run_phase(4, 1);
    chk("m3_done", done, 1);
    step();
    chk("m3_idle", phase, 0);

    // lid violation in WASH at remaining=2, prescaler=1
    start = 1'b1; step(); start = 1'b0;
    chk("lv_cur_mode", cur_mode, 0);
    run_phase(1, 2);
    repeat (5) step();
    chk("lv_pre_rem", remaining, 2);
    lid_open = 1'b1; step();
    chk("lv_pause", phase, 5);
    chk("lv_fine", fine_pulse, 1);
    chk("lv_viol", viol_cnt, 1);
    chk("lv_rem", remaining, 2);
    chk("lv_lock", lid_lock, 0);
    chk("lv_busy", busy, 1);
    for (int i = 0; i < 9; i++) begin
      start = (i == 3);
      step();
      chk("lv_hold_phase", phase, 5);
      chk("lv_hold_fine", fine_pulse, 0);
      chk("lv_hold_rem", remaining, 2);
    end
    start = 1'b0; lid_open = 1'b0; step();
    chk("lv_closed_wait", phase, 5);
    start = 1'b1; step(); start = 1'b0;
    chk("lv_resume", phase, 2);
    chk("lv_resume_rem", remaining, 2);
    chk("lv_resume_lock", lid_lock, 1);
    step(); chk("lv_pre2", remaining, 2);
    step(); chk("lv_pre3", remaining, 2);
    step(); chk("lv_ticked", remaining, 1);
    chk("lv_viol_held", viol_cnt, 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("lv_abort", phase, 0);
    chk("lv_abort_viol", viol_cnt, 1);

    // lid opens in FILL's final tick cycle
    start = 1'b1; step(); start = 1'b0;
    chk("bd_viol_clr", viol_cnt, 0);
    repeat (7) step();
    chk("bd_last", remaining, 1);
    lid_open = 1'b1; step(); lid_open = 1'b0;
    chk("bd_pause", phase, 5);
    chk("bd_rem", remaining, 1);
    chk("bd_fine", fine_pulse, 1);
    step();
    chk("bd_wait", phase, 5);
    start = 1'b1; step(); start = 1'b0;
    chk("bd_resume", phase, 1);
    chk("bd_resume_rem", remaining, 1);
    step();
    chk("bd_wash", phase, 2);
    chk("bd_wash_rem", remaining, 3);

    // abort in RINSE with the lid opening at the same time
    repeat (12) step();
    chk("ab_rinse", phase, 3);
    abort = 1'b1; lid_open = 1'b1; step(); abort = 1'b0; lid_open = 1'b0;
    chk("ab_phase", phase, 0);
    chk("ab_fine", fine_pulse, 0);
    chk("ab_done", done, 0);
    chk("ab_rem", remaining, 0);
    chk("ab_busy", busy, 0);
    chk("ab_viol", viol_cnt, 1);

    // 16 violations saturate the counter
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lid_open = 1'b1; step(); lid_open = 1'b0;
      start = 1'b1; step(); start = 1'b0;
    end
    chk("sat_phase", phase, 1);
    chk("sat_rem", remaining, 2);
    chk("sat_viol", viol_cnt, 15);
    abort = 1'b1; step(); abort = 1'b0;
    chk("sat_held", viol_cnt, 15);
    start = 1'b1; step(); start = 1'b0;
    chk("sat_cleared", viol_cnt, 0);

    // asynchronous reset mid-SPIN
    run_phase(1, 2);
    run_phase(2, 3);
    run_phase(3, 2);
    step(); step();
    chk("rs_spin", phase, 4);
    chk("rs_lock", lid_lock, 1);
    #2 rst = 1'b0;
    #1 chk_reset_vals("async_reset");
    #1 rst = 1'b1;
    lid_open = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("rs_lid_start", phase, 0);
    chk("rs_lid_busy", busy, 0);
    lid_open = 1'b0; step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
- Cycle controller for the washing-machine datapath. Takes the mode selected on the admin/user panel and steps the machine through FILL, WASH, RINSE and SPIN using per-phase second timers.
- Enforces the lid interlock. Pauses on a lid violation and raises a one-cycle fine event for the billing logic, which applies setfine.
- Exports phase and remaining seconds for the seven-segment scan drivers.

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second tick (≥2).
- FILL_S, 8'd10: FILL duration in seconds.
- WASH_S0, 8'd20: WASH duration, mode 0 (quick).
- WASH_S1, 8'd40: WASH duration, mode 1 (standard).
- WASH_S2, 8'd60: WASH duration, mode 2 (heavy).
- WASH_S3, 8'd0: WASH duration, mode 3 (rinse-only).
- RINSE_S, 8'd20: RINSE duration in seconds.
- SPIN_S, 8'd15: SPIN duration in seconds.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse (debounced button): begin cycle in IDLE, resume in PAUSE.
- abort  in  1  one-cycle pulse: cancel the cycle.
- mode  in  2  wash mode; sampled only when start is accepted in IDLE.
- lid_open  in  1  level; 1 = lid open.
- phase  out  3  0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 PAUSE, 6 DONE.
- remaining  out  8  seconds left in the current/paused phase; 0 in IDLE/DONE.
- busy  out  1  1 in states FILL..PAUSE.
- lid_lock  out  1  1 in FILL, WASH, RINSE, SPIN; 0 in PAUSE/IDLE/DONE.
- fine_pulse  out  1  one-cycle pulse on each lid violation.
- viol_cnt  out  4  violations this cycle; saturates at 15.
- done  out  1  one-cycle pulse on normal completion.
- cur_mode  out  2  latched mode.

Behaviour:
- Reset: phase=IDLE, remaining=0, busy=0, lid_lock=0, fine_pulse=0, viol_cnt=0, done=0, cur_mode=0, prescaler=0, saved phase=FILL. All outputs are registered.
- IDLE:
  - start=1 and lid_open=0: latch cur_mode=mode, clear viol_cnt and prescaler, go FILL with remaining=FILL_S on the next edge.
  - start while lid_open=1: ignored.
  - abort: ignored.
- Run phases (FILL, WASH, RINSE, SPIN):
  - Prescaler counts 0..TICK_DIV-1. The tick fires in the cycle where the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - On tick: remaining decrements. If remaining was 1, advance to the next phase instead: load the next duration and clear the prescaler. Each phase therefore lasts exactly duration×TICK_DIV cycles.
  - Order: FILL→WASH (WASH_S[cur_mode])→RINSE→SPIN→DONE.
  - A loaded duration of 0 (e.g. mode 3 WASH) holds that phase for exactly 1 cycle, then advances (no tick needed).
- Lid violation: lid_open=1 in a run phase means:
  - next state PAUSE; save the current phase;
  - remaining and prescaler are frozen;
  - fine_pulse=1 for that one cycle;
  - viol_cnt+1, saturating at 15.
  - Staying in PAUSE with the lid open produces no further fines.
- PAUSE:
  - start=1 and lid_open=0: return to the saved phase. remaining and prescaler resume from their frozen values, with no reload.
  - start with the lid open: ignored.
- DONE: held one cycle. done=1 during it, remaining=0, then IDLE. viol_cnt is held until the next accepted start.
- abort in any busy state or DONE: next state IDLE, remaining=0, no done pulse, viol_cnt held.
- Same-cycle priority: abort > lid_open > tick/phase advance > start.
  - A lid violation in a run phase's final tick cycle freezes remaining=1 and prescaler=TICK_DIV-1. After resume, the first cycle ticks and advances.
  - start is ignored in run phases.
- Reset mid-operation: immediate return to reset values regardless of state. lid_lock drops asynchronously.
- Arithmetic: remaining is 8-bit unsigned and never underflows. The prescaler width is $clog2(TICK_DIV).

Test Plan (TICK_DIV=4, FILL_S=2, WASH_S0=3, WASH_S3=0, RINSE_S=2, SPIN_S=1):
- Normal mode 0:
  - Stimulus: start pulse at edge 0, lid closed.
  - Response: FILL for 8 cycles (remaining 2→1), WASH 12, RINSE 8, SPIN 4, DONE 1 cycle with done=1, then IDLE.
  - lid_lock=1 for exactly 32 cycles; fine_pulse never asserts.
- Mode 3:
  - Stimulus: start with mode=3.
  - Response: FILL 8 cycles, WASH exactly 1 cycle with remaining=0, RINSE 8, SPIN 4, done pulse.
- Lid violation:
  - Stimulus: lid_open=1 held 10 cycles starting in WASH at remaining=2, prescaler=1.
  - Response: PAUSE, a single fine_pulse, viol_cnt=1, remaining stays 2.
  - Then start after the lid closes: WASH resumes, with 2 cycles until the next tick.
  - Start pulsed while the lid is still open: no effect.
- Boundary:
  - Stimulus: lid_open in the last-tick cycle of FILL.
  - Response: PAUSE with remaining=1; after resume, WASH is entered on the following edge.
- Abort:
  - Stimulus: abort in RINSE together with lid_open.
  - Response: IDLE next cycle, no fine_pulse, no done, remaining=0.
  - Also: 16 violations within one cycle leave viol_cnt=15; the next start clears it to 0.
- Reset:
  - Stimulus: rst low asynchronously mid-SPIN.
  - Response: all outputs return to reset values before the next edge; start in IDLE while lid_open=1 is ignored.
